// File: rtl/vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// vga_sync_decoder
//
// Receive-side VGA timing recovery. Samples an incoming active-low hsync /
// vsync pair on pixel-enable cycles, regenerates x/y beam coordinates,
// measures line length and frame height, and declares `locked` once the
// timing has matched the configured mode for LOCK_FRAMES consecutive frames.
//
// Optional feature (compile-time macro VGA_SYNC_WIDTH_CHECK_EN):
//   when defined, the hsync low width is measured and checked against
//   H_SYNC_W; when undefined, hsync_width is held at 0 and never checked.
//
// Parameters:
//   H_TOTAL      expected pixels per line
//   V_TOTAL      expected lines per frame
//   H_SYNC_W     expected hsync low width (width-check build only)
//   LOCK_FRAMES  consecutive good frames needed to lock, 1..15
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   clk_pixel    pixel enable; all sampling/counting happens only when 1
//   hsync        horizontal sync, active low
//   vsync        vertical sync, active low
//   x            pixels since last hsync fall (saturates at 2047)
//   y            hsync falls since last vsync fall
//   line_len     length of the last completed line
//   frame_lines  line count of the last completed frame
//   hsync_width  last measured hsync low width
//   frame_start  one-clk pulse on a vsync fall
//   sync_err     one-clk pulse on a timing mismatch
//   locked       high while the timing is verified
// ---------------------------------------------------------------------------
module vga_sync_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_SYNC_W    = 96,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_pixel,
  input  logic        hsync,
  input  logic        vsync,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic [10:0] line_len,
  output logic [10:0] frame_lines,
  output logic [10:0] hsync_width,
  output logic        frame_start,
  output logic        sync_err,
  output logic        locked
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam logic [10:0] CNT_MAX   = 11'h7ff;
  localparam logic [10:0] H_TOTAL_C = 11'(H_TOTAL);
  localparam logic [10:0] V_TOTAL_C = 11'(V_TOTAL);
  localparam logic [3:0]  LOCK_C    = 4'(LOCK_FRAMES);

  if (LOCK_FRAMES < 1 || LOCK_FRAMES > 15) begin : g_bad_lock_frames
    $error("vga_sync_decoder: LOCK_FRAMES must be in 1..15");
  end
  if (H_SYNC_W < 1 || H_SYNC_W > 2047) begin : g_bad_hsync_w
    $error("vga_sync_decoder: H_SYNC_W must be in 1..2047");
  end

  state_e      state_q, state_d;
  logic [3:0]  good_cnt_q, good_cnt_d;
  logic        frame_bad_q, frame_bad_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic [10:0] line_len_q, line_len_d;
  logic [10:0] frame_lines_q, frame_lines_d;
  logic        frame_start_q, frame_start_d;
  logic        sync_err_q, sync_err_d;
  logic        locked_q, locked_d;

  logic        hs_fall, vs_fall;
  logic        line_err;   // bad line length (or bad width) seen this cycle
  logic        lines_ok;   // captured frame height matches, valid on vs_fall
  logic        lost;       // x saturated: no hsync seen for a whole counter span
  logic [3:0]  cnt_inc;

`ifdef VGA_SYNC_WIDTH_CHECK_EN
  localparam logic [10:0] H_SYNC_W_C = 11'(H_SYNC_W);
  logic [10:0] wcnt_q, wcnt_d;
  logic [10:0] hsync_width_q, hsync_width_d;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    good_cnt_d    = good_cnt_q;
    frame_bad_d   = frame_bad_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    x_d           = x_q;
    y_d           = y_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    frame_start_d = 1'b0;
    sync_err_d    = 1'b0;
    hs_fall       = 1'b0;
    vs_fall       = 1'b0;
    line_err      = 1'b0;
    lines_ok      = 1'b0;
    lost          = 1'b0;
    cnt_inc       = good_cnt_q + 4'd1;
`ifdef VGA_SYNC_WIDTH_CHECK_EN
    wcnt_d        = wcnt_q;
    hsync_width_d = hsync_width_q;
`endif

    if (clk_pixel) begin
      hs_fall = hs_q & ~hsync;
      vs_fall = vs_q & ~vsync;
      hs_d    = hsync;
      vs_d    = vsync;

      // Horizontal counter.
      if (hs_fall) begin
        line_len_d = x_q + 11'd1;
        x_d        = '0;
        y_d        = y_q + 11'd1;
        line_err   = (line_len_d != H_TOTAL_C);
      end else if (x_q != CNT_MAX) begin
        x_d = x_q + 11'd1;
      end

`ifdef VGA_SYNC_WIDTH_CHECK_EN
      // Width counter restarts at 1 on the falling sample so that a pulse
      // sampled low on N pixel cycles measures N at the rising sample.
      if (!hsync) begin
        if (hs_fall)              wcnt_d = 11'd1;
        else if (wcnt_q != CNT_MAX) wcnt_d = wcnt_q + 11'd1;
      end
      if (!hs_q && hsync) begin
        hsync_width_d = wcnt_q;
        if (wcnt_q != H_SYNC_W_C) line_err = 1'b1;
      end
`endif

      // Vertical counter; a coincident hsync fall belongs to the ending frame.
      if (vs_fall) begin
        frame_lines_d = y_q + {10'd0, hs_fall};
        y_d           = '0;
        frame_start_d = 1'b1;
        frame_bad_d   = 1'b0;
        lines_ok      = (frame_lines_d == V_TOTAL_C);
      end else begin
        frame_bad_d = frame_bad_q | line_err;
      end

      lost = (x_d == CNT_MAX);

      if (lost) begin
        state_d    = ST_SEARCH;
        good_cnt_d = '0;
      end else begin
        case (state_q)
          ST_SEARCH: begin
            if (vs_fall) begin
              state_d    = ST_TRACK;
              good_cnt_d = '0;
            end
          end
          ST_TRACK: begin
            if (vs_fall) begin
              if (!frame_bad_q && !line_err && lines_ok) begin
                good_cnt_d = cnt_inc;
                if (cnt_inc == LOCK_C) state_d = ST_LOCKED;
              end else begin
                // Mid-frame line errors were already reported when they
                // happened; only report what is new at this boundary.
                good_cnt_d = '0;
                sync_err_d = line_err | ~lines_ok;
              end
            end else if (line_err) begin
              sync_err_d = 1'b1;
            end
          end
          ST_LOCKED: begin
            if (line_err || (vs_fall && !lines_ok)) begin
              state_d    = ST_TRACK;
              good_cnt_d = '0;
              sync_err_d = 1'b1;
            end
          end
          default: begin
            state_d    = ST_SEARCH;
            good_cnt_d = '0;
          end
        endcase
      end
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // NOTE: the reset is asynchronous, so it sits in the sensitivity list and
  // every flop here returns to its reset value without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_SEARCH;
      good_cnt_q    <= '0;
      frame_bad_q   <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      x_q           <= '0;
      y_q           <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
      locked_q      <= 1'b0;
`ifdef VGA_SYNC_WIDTH_CHECK_EN
      wcnt_q        <= '0;
      hsync_width_q <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so all flops sample the same
      // pre-edge values regardless of statement order.
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
      frame_bad_q   <= frame_bad_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      frame_start_q <= frame_start_d;
      sync_err_q    <= sync_err_d;
      locked_q      <= locked_d;
`ifdef VGA_SYNC_WIDTH_CHECK_EN
      wcnt_q        <= wcnt_d;
      hsync_width_q <= hsync_width_d;
`endif
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign frame_start = frame_start_q;
  assign sync_err    = sync_err_q;
  assign locked      = locked_q;
`ifdef VGA_SYNC_WIDTH_CHECK_EN
  assign hsync_width = hsync_width_q;
`else
  assign hsync_width = '0;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_decoder
//
// Directed bench for vga_sync_decoder using a reduced mode (20 pixels/line,
// 6 lines/frame, hsync width 4, lock after 2 good frames) so whole frames
// take a few hundred clocks. Pixels are enabled on every 2nd clk. Each frame
// starts with coincident hsync and vsync falls; vsync is low for lines 0..1.
// ---------------------------------------------------------------------------
module tb_vga_sync_decoder;

  localparam int H_T    = 20;
  localparam int V_T    = 6;
  localparam int HSW    = 4;
  localparam int LOCK_N = 2;
`ifdef VGA_SYNC_WIDTH_CHECK_EN
  localparam bit WCHK = 1'b1;
`else
  localparam bit WCHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_pixel;
  logic        hsync;
  logic        vsync;
  logic [10:0] x, y, line_len, frame_lines, hsync_width;
  logic        frame_start, sync_err, locked;

  int n_cmp   = 0;
  int n_bad   = 0;
  int fs_cnt  = 0;   // frame_start pulses observed
  int err_cnt = 0;   // sync_err pulses observed

  vga_sync_decoder #(
    .H_TOTAL    (H_T),
    .V_TOTAL    (V_T),
    .H_SYNC_W   (HSW),
    .LOCK_FRAMES(LOCK_N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_pixel  (clk_pixel),
    .hsync      (hsync),
    .vsync      (vsync),
    .x          (x),
    .y          (y),
    .line_len   (line_len),
    .frame_lines(frame_lines),
    .hsync_width(hsync_width),
    .frame_start(frame_start),
    .sync_err   (sync_err),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  // One pixel: enable for one clk, then sample pulses at the following
  // negedge (between the sampling edge and the edge that clears them).
  task automatic pix(input logic h, input logic v);
    @(negedge clk);
    clk_pixel = 1'b1;
    hsync     = h;
    vsync     = v;
    @(negedge clk);
    clk_pixel = 1'b0;
    if (frame_start === 1'b1) fs_cnt++;
    if (sync_err === 1'b1) err_cnt++;
  endtask

  task automatic line_seg(input int p0, input int p1, input int hsw, input logic v);
    for (int p = p0; p < p1; p++) pix((p < hsw) ? 1'b0 : 1'b1, v);
  endtask

  task automatic frame_part(input int l0, input int l1, input int bad_idx,
                            input int bad_len, input int bad_hsw);
    for (int l = l0; l < l1; l++)
      line_seg(0, (l == bad_idx) ? bad_len : H_T, (l == bad_idx) ? bad_hsw : HSW,
               (l < 2) ? 1'b0 : 1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b1; clk_pixel = 1'b0; hsync = 1'b1; vsync = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if ({x, y, line_len, frame_lines, hsync_width} !== 55'd0) begin n_bad++; $display("FAIL reset_counters: got %h want 0", {x, y, line_len, frame_lines, hsync_width}); end
    n_cmp++; if ({frame_start, sync_err, locked} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {frame_start, sync_err, locked}); end
    rst = 1'b0;
  endtask

  task automatic test_lock;
    int fs0, e0;
    fs0 = fs_cnt; e0 = err_cnt;
    frame_part(0, V_T, -1, 0, 0);
    frame_part(0, V_T, -1, 0, 0);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL lock_after_2_falls: got %b want 0", locked); end
    n_cmp++; if (fs_cnt - fs0 != 2) begin n_bad++; $display("FAIL frame_start_count: got %0d want 2", fs_cnt - fs0); end
    n_cmp++; if (frame_lines !== 11'd6) begin n_bad++; $display("FAIL frame_lines: got %0d want 6", frame_lines); end
    n_cmp++; if (line_len !== 11'd20) begin n_bad++; $display("FAIL line_len: got %0d want 20", line_len); end
    n_cmp++; if (hsync_width !== (WCHK ? 11'd4 : 11'd0)) begin n_bad++; $display("FAIL hsync_width_clean: got %0d want %0d", hsync_width, WCHK ? 4 : 0); end
    line_seg(0, H_T, HSW, 1'b0);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL lock_after_3_falls: got %b want 1", locked); end
    n_cmp++; if (fs_cnt - fs0 != 3) begin n_bad++; $display("FAIL frame_start_count3: got %0d want 3", fs_cnt - fs0); end
    frame_part(1, 3, -1, 0, 0);
    n_cmp++; if (x !== 11'd19 || y !== 11'd2) begin n_bad++; $display("FAIL xy_line_end: got x=%0d y=%0d want x=19 y=2", x, y); end
    n_cmp++; if (err_cnt != e0) begin n_bad++; $display("FAIL err_clean_lock: got %0d pulses want 0", err_cnt - e0); end
  endtask

  task automatic test_pixel_hold;
    int e0;
    e0 = err_cnt;
    line_seg(0, 7, HSW, 1'b1);
    n_cmp++; if (x !== 11'd6 || y !== 11'd3) begin n_bad++; $display("FAIL xy_before_hold: got x=%0d y=%0d want x=6 y=3", x, y); end
    hsync = 1'b0; vsync = 1'b0;   // must be ignored while clk_pixel is low
    repeat (50) @(negedge clk);
    n_cmp++; if (x !== 11'd6 || y !== 11'd3) begin n_bad++; $display("FAIL xy_frozen: got x=%0d y=%0d want x=6 y=3", x, y); end
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL lock_during_hold: got %b want 1", locked); end
    line_seg(7, H_T, HSW, 1'b1);
    frame_part(4, V_T, -1, 0, 0);
    n_cmp++; if (x !== 11'd19 || y !== 11'd5) begin n_bad++; $display("FAIL xy_after_hold: got x=%0d y=%0d want x=19 y=5", x, y); end
    n_cmp++; if (locked !== 1'b1 || err_cnt != e0) begin n_bad++; $display("FAIL lock_after_hold: locked=%b err=%0d want 1/0", locked, err_cnt - e0); end
  endtask

  task automatic test_short_line;
    int e0;
    e0 = err_cnt;
    frame_part(0, 3, 2, 19, HSW);
    line_seg(0, 1, HSW, 1'b1);
    n_cmp++; if (line_len !== 11'd19) begin n_bad++; $display("FAIL short_line_len: got %0d want 19", line_len); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL short_line_unlock: got %b want 0", locked); end
    n_cmp++; if (err_cnt - e0 != 1) begin n_bad++; $display("FAIL short_line_err: got %0d pulses want 1", err_cnt - e0); end
    line_seg(1, H_T, HSW, 1'b1);
    frame_part(4, V_T, -1, 0, 0);
    frame_part(0, V_T, -1, 0, 0);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL relock_early1: got %b want 0", locked); end
    frame_part(0, V_T, -1, 0, 0);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL relock_early2: got %b want 0", locked); end
    line_seg(0, H_T, HSW, 1'b0);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL relock: got %b want 1", locked); end
    frame_part(1, V_T, -1, 0, 0);
    n_cmp++; if (err_cnt - e0 != 1) begin n_bad++; $display("FAIL short_line_err_total: got %0d pulses want 1", err_cnt - e0); end
  endtask

  task automatic test_signal_loss;
    int e0;
    bit found;
    e0 = err_cnt; found = 1'b0;
    for (int i = 0; i < 2100 && !found; i++) begin
      pix(1'b1, 1'b1);
      if (x === 11'd2046) found = 1'b1;
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL loss_timeout: x=%0d never reached 2046", x); end
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL loss_pre: got %b want 1", locked); end
    pix(1'b1, 1'b1);
    n_cmp++; if (x !== 11'd2047 || locked !== 1'b0) begin n_bad++; $display("FAIL loss_unlock: x=%0d locked=%b want 2047/0", x, locked); end
    repeat (3) pix(1'b1, 1'b1);
    n_cmp++; if (x !== 11'd2047) begin n_bad++; $display("FAIL x_saturate: got %0d want 2047", x); end
    frame_part(0, V_T, -1, 0, 0);
    frame_part(0, V_T, -1, 0, 0);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL loss_relock_early: got %b want 0", locked); end
    line_seg(0, H_T, HSW, 1'b0);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL loss_relock: got %b want 1", locked); end
    n_cmp++; if (err_cnt != e0) begin n_bad++; $display("FAIL loss_err: got %0d pulses want 0", err_cnt - e0); end
    frame_part(1, V_T, -1, 0, 0);
  endtask

  task automatic test_hsync_width;
    int e0;
    e0 = err_cnt;
    frame_part(0, 2, -1, 0, 0);
    line_seg(0, 5, 3, 1'b1);
    n_cmp++; if (hsync_width !== (WCHK ? 11'd3 : 11'd0)) begin n_bad++; $display("FAIL narrow_width: got %0d want %0d", hsync_width, WCHK ? 3 : 0); end
    n_cmp++; if (locked !== !WCHK) begin n_bad++; $display("FAIL narrow_lock: got %b want %b", locked, !WCHK); end
    n_cmp++; if (err_cnt - e0 != (WCHK ? 1 : 0)) begin n_bad++; $display("FAIL narrow_err: got %0d pulses want %0d", err_cnt - e0, WCHK ? 1 : 0); end
    line_seg(5, H_T, 3, 1'b1);
    frame_part(3, V_T, -1, 0, 0);
    frame_part(0, V_T, -1, 0, 0);
    n_cmp++; if (locked !== !WCHK) begin n_bad++; $display("FAIL narrow_relock_early: got %b want %b", locked, !WCHK); end
    frame_part(0, V_T, -1, 0, 0);
    line_seg(0, H_T, HSW, 1'b0);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL narrow_relock: got %b want 1", locked); end
    n_cmp++; if (hsync_width !== (WCHK ? 11'd4 : 11'd0)) begin n_bad++; $display("FAIL width_restored: got %0d want %0d", hsync_width, WCHK ? 4 : 0); end
  endtask

  task automatic test_async_reset;
    int fs0;
    frame_part(1, 3, -1, 0, 0);
    line_seg(0, 9, HSW, 1'b1);
    n_cmp++; if (x !== 11'd8 || y !== 11'd3 || locked !== 1'b1) begin n_bad++; $display("FAIL pre_reset: x=%0d y=%0d locked=%b want 8/3/1", x, y, locked); end
    #2 rst = 1'b1;
    #1;   // still well before the next rising clk edge
    n_cmp++; if ({x, y, line_len, frame_lines, hsync_width} !== 55'd0) begin n_bad++; $display("FAIL async_rst_counters: got %h want 0", {x, y, line_len, frame_lines, hsync_width}); end
    n_cmp++; if ({frame_start, sync_err, locked} !== 3'b000) begin n_bad++; $display("FAIL async_rst_flags: got %b want 000", {frame_start, sync_err, locked}); end
    @(negedge clk);
    rst = 1'b0;
    fs0 = fs_cnt;
    frame_part(0, V_T, -1, 0, 0);
    frame_part(0, V_T, -1, 0, 0);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL post_rst_early: got %b want 0", locked); end
    line_seg(0, H_T, HSW, 1'b0);
    n_cmp++; if (locked !== 1'b1 || fs_cnt - fs0 != 3) begin n_bad++; $display("FAIL post_rst_relock: locked=%b fs=%0d want 1/3", locked, fs_cnt - fs0); end
    n_cmp++; if (frame_lines !== 11'd6 || line_len !== 11'd20) begin n_bad++; $display("FAIL post_rst_meas: lines=%0d len=%0d want 6/20", frame_lines, line_len); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_pixel_hold();
    test_short_line();
    test_signal_loss();
    test_hsync_width();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Recovers pixel timing from an incoming VGA hsync/vsync pair: regenerates x/y beam coordinates, measures line length, frame height and hsync pulse width, and asserts `locked` once the timing matches the configured mode for several consecutive frames. It is the receive-side counterpart of the VGA timing generator. It sits in loopback and self-check paths, fed from the generator's sync outputs, and gates downstream logic that needs trustworthy coordinates.

## Interface
- `H_TOTAL`, 800, expected pixels per line.
- `V_TOTAL`, 525, expected lines per frame.
- `H_SYNC_W`, 96, expected hsync low width in pixels; used only with the width-check option.
- `LOCK_FRAMES`, 2, consecutive good frames required to lock; range 1..15.
- `clk  in  1`  system clock.
- `rst  in  1`  reset, asynchronous, active-high.
- `clk_pixel  in  1`  pixel enable; all sampling and counting happen only on `clk` edges where it is 1.
- `hsync  in  1`  horizontal sync, active low.
- `vsync  in  1`  vertical sync, active low.
- `x  out  11`  pixel count since last hsync fall.
- `y  out  11`  hsync falls since last vsync fall.
- `line_len  out  11`  length of last completed line.
- `frame_lines  out  11`  line count of last completed frame.
- `hsync_width  out  11`  last measured hsync low width.
- `frame_start  out  1`  one-`clk` pulse on a vsync fall.
- `sync_err  out  1`  one-`clk` pulse on a timing mismatch.
- `locked  out  1`  timing verified.

## Operation
- Reset values: all counters and outputs 0. Internal `hs_q`/`vs_q` = 1, so a low sync level right after reset produces no edge.
- Edges are evaluated only on `clk_pixel` cycles:
  - hsync fall: `hs_q`=1 and `hsync`=0.
  - vsync fall: `vs_q`=1 and `vsync`=0.
  - `hs_q`/`vs_q` update only on `clk_pixel` cycles.
- Horizontal counter, on each `clk_pixel` cycle:
  - hsync fall: `line_len` <= `x`+1; `x` <= 0; `y` <= `y`+1.
  - otherwise: `x` <= `x`+1, saturating at 2047.
- Vertical counter, on vsync fall:
  - `frame_lines` <= `y` + (1 if hsync fall in the same cycle, else 0).
  - `y` <= 0; `frame_start` pulses.
  - A coincident hsync fall still zeroes `x`.
- Per-frame flag `frame_bad`:
  - cleared on vsync fall.
  - set by any hsync fall whose captured length ≠ `H_TOTAL`.
- States:
  - SEARCH → TRACK on first vsync fall; good-frame count = 0. No checking in SEARCH.
  - TRACK, on each vsync fall: if `frame_bad`=0 and captured `frame_lines`=`V_TOTAL`, increment count. On reaching `LOCK_FRAMES`, go to LOCKED. Otherwise count = 0 and `sync_err` pulses.
  - TRACK, mid-frame line mismatch: `sync_err` pulses immediately; count is cleared at the frame's vsync fall.
  - LOCKED: any line or frame mismatch → TRACK, count = 0, `sync_err` pulses, `locked` = 0.
  - Any state: `x` reaching 2047 (signal lost) → SEARCH, `locked` = 0, no `sync_err`.
- `locked` = 1 exactly while in LOCKED.
- Reset mid-operation returns immediately to SEARCH with all reset values.

## Timing
- `x`, `y`, `line_len`, `frame_lines` update on the same `clk` edge that samples the edge; registered, zero extra latency.
- `frame_start`, `sync_err`, and the `locked` change are visible in the `clk` cycle after the sampling edge; each pulse lasts one `clk` cycle.
- With `clk_pixel`=0, all state holds.
- Clean input, `LOCK_FRAMES`=N: `locked` rises after the (N+1)th vsync fall following reset.

## Configuration
- Macro: `VGA_SYNC_WIDTH_CHECK_EN`.
- Defined:
  - A width counter runs while `hsync` is low.
  - On hsync rise: `hsync_width` <= low count; if it ≠ `H_SYNC_W`, sets `frame_bad` and raises a mismatch like a bad line.
- Undefined: no width counter; `hsync_width` is held at 0; width is never checked.

## Test plan
- Assert `rst` asynchronously mid-frame while locked → all outputs 0 with no clock edge; relock follows the normal sequence.
- Drive 800×525 timing, `clk_pixel` every 2nd `clk`, `LOCK_FRAMES`=2 → `line_len`=800, `frame_lines`=525, `locked` rises after the 3rd vsync fall, `frame_start` pulses once per frame.
- While locked, shorten one line to 799 → `sync_err` pulses once, `locked` drops; relocks after the 2 following clean frames.
- Hold `hsync` high → once `x` reaches 2047, `locked`=0, state is SEARCH, no `sync_err`; restoring sync relocks after 3 vsync falls.
- Hold `clk_pixel` low 50 cycles mid-line → `x`/`y` are frozen, and lock is unaffected.
- Use hsync width 95 with the macro defined → `hsync_width`=95, `sync_err` pulses, lock is lost; same stimulus without the macro → remains locked, `hsync_width`=0.
